letc_core_stage_fifo: RTL and testbench

- Parametrised elastic buffer placed between LETC Core pipeline stages, e.g. F1->F2 (32-bit payload) or F2->D (64-bit payload).
- Replaces the fixed single-entry stage register with:
  - a DEPTH-entry circular buffer using a valid/ready handshake on both sides;
  - a synchronous flush for branch/trap redirects;
  - two selectable ready modes.
- Payload is an opaque WIDTH-bit vector; callers pack/unpack the stage structs.

---
 rtl/letc_core_stage_fifo.sv | 106 ++++++++++
 tb/tb_letc_core_stage_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_stage_fifo.sv
// Elastic stage buffer for the LETC Core pipeline. It is a DEPTH-entry circular FIFO
// with valid/ready on both sides, a synchronous redirect flush and a selectable ready mode.
module letc_core_stage_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 2,
    parameter bit PASS_READY = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [WIDTH-1:0]           i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [WIDTH-1:0]           o_out_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (DEPTH == 1) begin
            return '0;
        end
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    generate
        if (PASS_READY) begin : g_pass_ready
            assign o_in_ready = !full || i_out_ready;
        end else begin : g_registered_ready
            assign o_in_ready = !full;
        end
    endgenerate

    assign push = i_in_valid && o_in_ready && !i_flush;
    assign pop  = o_out_valid && i_out_ready && !i_flush;

    assign o_out_valid = !empty;
    assign o_out_data  = entries[rd_ptr];
    assign o_count     = count;
    assign o_empty     = empty;
    assign o_full      = full;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // On a full pass-through, wr_ptr equals rd_ptr, so the write lands in the slot being read out.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            entries[wr_ptr] <= i_in_data;
        end
    end

    a_count_bound : assert property (
        @(posedge i_clk) disable iff (!i_rst_n) count <= CW'(DEPTH)
    );

    a_no_push_when_not_ready : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (!o_in_ready && !i_flush) |=> (wr_ptr == $past(wr_ptr))
    );

endmodule

// File: tb/tb_letc_core_stage_fifo.sv
// Scoreboard bench for letc_core_stage_fifo. It uses three instances: (D2, pass-ready),
// (D3, registered ready) and (D2, registered ready).
module tb_letc_core_stage_fifo;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  flush;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  empty;
    logic [2:0]  full;
    logic [63:0] in_data  [3];
    logic [63:0] out_data [3];
    logic [1:0]  count    [3];

    logic [63:0] exp_q[$];
    int          sel = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            letc_core_stage_fifo #(
                .WIDTH(64),
                .DEPTH((g == 1) ? 3 : 2),
                .PASS_READY((g == 0) ? 1'b1 : 1'b0)
            ) dut (
                .i_clk(clk),
                .i_rst_n(rst_n[g]),
                .i_flush(flush[g]),
                .i_in_valid(in_valid[g]),
                .o_in_ready(in_ready[g]),
                .i_in_data(in_data[g]),
                .o_out_valid(out_valid[g]),
                .i_out_ready(out_ready[g]),
                .o_out_data(out_data[g]),
                .o_count(count[g]),
                .o_empty(empty[g]),
                .o_full(full[g])
            );
        end
    endgenerate

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s (dut %0d): got 0x%0h, expected 0x%0h", name, sel, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [63:0] d, input logic r, input logic f);
        in_valid[sel]  = v;
        in_data[sel]   = d;
        out_ready[sel] = r;
        flush[sel]     = f;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [1:0] c, input logic v, input logic e, input logic fl);
        check_output({name, ".count"}, 64'(count[sel]), 64'(c));
        check_output({name, ".out_valid"}, 64'(out_valid[sel]), 64'(v));
        check_output({name, ".empty"}, 64'(empty[sel]), 64'(e));
        check_output({name, ".full"}, 64'(full[sel]), 64'(fl));
    endtask

    // The monitor pops from the scoreboard whenever a consuming handshake is visible before the edge.
    initial begin
        logic [63:0] want;
        forever begin
            @(negedge clk);
            if (rst_n[sel] && !flush[sel] && out_valid[sel] && out_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL scoreboard (dut %0d): unexpected output 0x%0h, expected none", sel, out_data[sel]);
                end else begin
                    want = exp_q.pop_front();
                    check_output("scoreboard", out_data[sel], want);
                end
            end
        end
    end

    initial begin
        rst_n     = 3'b000;
        flush     = 3'b000;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_data[i] = '0;
        end

        cycle();
        cycle();
        sel = 0;
        check_state("reset", 2'd0, 1'b0, 1'b1, 1'b0);
        check_output("reset.out_data", out_data[0], 64'h0);
        check_output("reset.in_ready", 64'(in_ready[0]), 64'd1);
        sel = 1;
        check_output("reset.count", 64'(count[1]), 64'd0);
        check_output("reset.in_ready", 64'(in_ready[1]), 64'd1);
        rst_n = 3'b111;

        // Fill and drain order on D3 with registered ready.
        sel = 1;
        apply_stimulus(1'b1, 64'hA, 1'b0, 1'b0); exp_q.push_back(64'hA);
        cycle();
        check_output("fill.count1", 64'(count[1]), 64'd1);
        apply_stimulus(1'b1, 64'hB, 1'b0, 1'b0); exp_q.push_back(64'hB);
        cycle();
        check_output("fill.count2", 64'(count[1]), 64'd2);
        apply_stimulus(1'b1, 64'hC, 1'b0, 1'b0); exp_q.push_back(64'hC);
        cycle();
        check_state("fill.full", 2'd3, 1'b1, 1'b0, 1'b1);
        check_output("fill.in_ready", 64'(in_ready[1]), 64'd0);
        apply_stimulus(1'b1, 64'hD, 1'b1, 1'b0);
        #1;
        check_output("fill.in_ready_with_out_ready", 64'(in_ready[1]), 64'd0);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        cycle();
        cycle();
        check_state("drain.empty", 2'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Full pass-through on D2 with pass-ready.
        sel = 0;
        apply_stimulus(1'b1, 64'h1, 1'b0, 1'b0); exp_q.push_back(64'h1);
        cycle();
        apply_stimulus(1'b1, 64'h2, 1'b0, 1'b0); exp_q.push_back(64'h2);
        cycle();
        check_state("pass.full", 2'd2, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 64'h3, 1'b1, 1'b0); exp_q.push_back(64'h3);
        #1;
        check_output("pass.in_ready", 64'(in_ready[0]), 64'd1);
        cycle();
        check_output("pass.count_steady", 64'(count[0]), 64'd2);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        cycle();
        check_state("pass.drained", 2'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Same stimulus on D2 with registered ready: push refused while full.
        sel = 2;
        apply_stimulus(1'b1, 64'h1, 1'b0, 1'b0); exp_q.push_back(64'h1);
        cycle();
        apply_stimulus(1'b1, 64'h2, 1'b0, 1'b0); exp_q.push_back(64'h2);
        cycle();
        apply_stimulus(1'b1, 64'h3, 1'b1, 1'b0);
        #1;
        check_output("noPass.in_ready", 64'(in_ready[2]), 64'd0);
        cycle();
        check_output("noPass.count_after_pop", 64'(count[2]), 64'd1);
        check_output("noPass.in_ready_after_pop", 64'(in_ready[2]), 64'd1);
        exp_q.push_back(64'h3);
        cycle();
        check_output("noPass.count_held_upstream", 64'(count[2]), 64'd1);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        check_state("noPass.drained", 2'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Wrap-around on D3: continuous push/pop pairs with one-cycle latency.
        sel = 1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 64'(i), 1'b1, 1'b0);
            exp_q.push_back(64'(i));
            if (i == 0) begin
                #1;
                check_output("wrap.no_flow_through", 64'(out_valid[1]), 64'd0);
            end
            cycle();
            check_output("wrap.count", 64'(count[1]), 64'd1);
            check_output("wrap.latency_data", out_data[1], 64'(i));
        end
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        check_output("wrap.final_count", 64'(count[1]), 64'd0);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Flush with a simultaneous push on D2 with pass-ready.
        sel = 0;
        apply_stimulus(1'b1, 64'hA1, 1'b0, 1'b0);
        cycle();
        apply_stimulus(1'b1, 64'hA2, 1'b0, 1'b0);
        cycle();
        check_output("flush.pre_count", 64'(count[0]), 64'd2);
        apply_stimulus(1'b1, 64'hF, 1'b1, 1'b1);
        cycle();
        check_state("flush.after", 2'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 64'h5, 1'b0, 1'b0); exp_q.push_back(64'h5);
        cycle();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check_output("flush.new_data", out_data[0], 64'h5);
        check_output("flush.new_count", 64'(count[0]), 64'd1);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        cycle();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        // Backpressure stability, then reset while two entries are held.
        apply_stimulus(1'b1, 64'h11, 1'b0, 1'b0);
        cycle();
        apply_stimulus(1'b1, 64'h22, 1'b0, 1'b0);
        cycle();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_output("stall.data", out_data[0], 64'h11);
            check_output("stall.valid", 64'(out_valid[0]), 64'd1);
        end
        rst_n[0] = 1'b0;
        cycle();
        check_state("midReset", 2'd0, 1'b0, 1'b1, 1'b0);
        check_output("midReset.out_data", out_data[0], 64'h0);
        check_output("midReset.in_ready", 64'(in_ready[0]), 64'd1);
        rst_n[0] = 1'b1;
        cycle();

        check_output("scoreboard.leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
